// File: rtl/call_request_encoder.sv
// Pends floor calls from synchronized button rising edges and emits them round-robin, GAP idle cycles apart.
// Build with CALL_DEBOUNCE_EN to gate each call on DEBOUNCE_CYCLES consecutive high samples.
module call_request_encoder #(
    parameter int NUM_FLOORS      = 16,
    parameter int GAP             = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_FLOORS-1:0] btn_i,
    input  logic [3:0]            floor_l1_i,
    input  logic [3:0]            floor_l2_i,
    output logic                  req_valid_o,
    output logic [3:0]            req_new_o,
    output logic [NUM_FLOORS-1:0] pending_o
);
    localparam int IW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;

    logic [NUM_FLOORS-1:0] sync1_q, sync2_q;
    logic [1:0]            primed_q;
    logic [NUM_FLOORS-1:0] event_w;

    // primed_q[1] marks the point where sync2_q first carries a real button sample after reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            primed_q <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            primed_q <= {primed_q[0], 1'b1};
        end
    end

`ifdef CALL_DEBOUNCE_EN
    logic [7:0]            cnt_q [NUM_FLOORS];
    logic [NUM_FLOORS-1:0] lock_q;

    // lock_q suppresses buttons held through reset until they are seen released
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_FLOORS; i++) cnt_q[i] <= '0;
            lock_q <= '1;
        end else begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (!sync2_q[i])
                    cnt_q[i] <= '0;
                else if (cnt_q[i] != 8'(DEBOUNCE_CYCLES))
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                if (primed_q[1] && !sync2_q[i])
                    lock_q[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        event_w = '0;
        for (int i = 0; i < NUM_FLOORS; i++)
            event_w[i] = sync2_q[i] && !lock_q[i] && (cnt_q[i] == 8'(DEBOUNCE_CYCLES - 1));
    end
`else
    logic [NUM_FLOORS-1:0] prev_q;

    // Previous level starts all-ones so a button held through reset shows no rising edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            prev_q <= '1;
        else if (primed_q[1])
            prev_q <= sync2_q;
    end

    assign event_w = sync2_q & ~prev_q;
`endif

    logic [NUM_FLOORS-1:0] pend_q, pend_d, at_lift, cand, emit_mask;
    logic [3:0]            rr_q, rr_d, gap_q, gap_d, new_q, new_d, sel;
    logic [IW-1:0]         idx;
    logic                  emit, found, valid_q;

    always_comb begin
        at_lift = '0;
        for (int i = 0; i < NUM_FLOORS; i++)
            at_lift[i] = (floor_l1_i == 4'(i)) || (floor_l2_i == 4'(i));
    end

    // Floors a lift is standing at are never offered for emission
    assign cand = pend_q & ~at_lift;

    always_comb begin
        sel   = rr_q;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < NUM_FLOORS; off++) begin
            idx = IW'((int'(rr_q) + off) % NUM_FLOORS);
            if (!found && cand[idx]) begin
                found = 1'b1;
                sel   = 4'(idx);
            end
        end
    end

    always_comb begin
        emit      = (gap_q == 4'd0) && found;
        emit_mask = emit ? (NUM_FLOORS'(1) << sel) : '0;
        pend_d    = (pend_q | event_w) & ~at_lift & ~emit_mask;
        rr_d      = rr_q;
        gap_d     = (gap_q != 4'd0) ? gap_q - 4'd1 : gap_q;
        new_d     = new_q;
        if (emit) begin
            rr_d  = (sel == 4'(NUM_FLOORS - 1)) ? 4'd0 : sel + 4'd1;
            gap_d = 4'(GAP);
            new_d = sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q  <= '0;
            rr_q    <= '0;
            gap_q   <= '0;
            new_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            rr_q    <= rr_d;
            gap_q   <= gap_d;
            new_q   <= new_d;
            valid_q <= emit;
        end
    end

    assign req_valid_o = valid_q;
    assign req_new_o   = new_q;
    assign pending_o   = pend_q;
endmodule

// File: tb/tb_call_request_encoder.sv
// Directed bench for call_request_encoder: vector table for the basic flow plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_call_request_encoder;
    localparam int NF  = 16;
    localparam int GP  = 2;
    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] btn;
    logic [3:0]  fl1, fl2;
    logic        req_valid;
    logic [3:0]  req_new;
    logic [15:0] pending;

    always #5 clk = ~clk;

    call_request_encoder #(.NUM_FLOORS(NF), .GAP(GP), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk_i(clk), .rst_ni(rst_n), .btn_i(btn), .floor_l1_i(fl1), .floor_l2_i(fl2),
        .req_valid_o(req_valid), .req_new_o(req_new), .pending_o(pending)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct { int t; logic [3:0] f; } emit_t;
    emit_t emq[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rst_n && req_valid) emq.push_back('{cyc, req_new});

    typedef struct {
        logic [15:0] btn; logic [3:0] fl1, fl2;
        logic vld; logic [3:0] nw; logic [15:0] pend;
    } vec_t;
    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        btn   = '0;
        #1;
        chk("reset valid", 32'(req_valid), 0);
        chk("reset new", 32'(req_new), 0);
        chk("reset pending", 32'(pending), 0);
        tick(2);
        rst_n = 1'b1;
        tick(4);
    endtask

    int m, pc, t1, n2;
    int exp_f[3];

    initial begin
        rst_n = 1'b0; btn = '0; fl1 = 4'd0; fl2 = 4'd1;
        do_reset();

`ifndef CALL_DEBOUNCE_EN
        // btn[5] held 3 cycles, then btn[7] at a lift, then floors 2 and 4 together
        tbl[0]  = '{16'h0000, 4'd0, 4'd1, 1'b0, 4'd0, 16'h0000};
        tbl[1]  = '{16'h0020, 4'd0, 4'd1, 1'b0, 4'd0, 16'h0000};
        tbl[2]  = '{16'h0020, 4'd0, 4'd1, 1'b0, 4'd0, 16'h0000};
        tbl[3]  = '{16'h0020, 4'd0, 4'd1, 1'b0, 4'd0, 16'h0020};
        tbl[4]  = '{16'h0000, 4'd0, 4'd1, 1'b1, 4'd5, 16'h0000};
        tbl[5]  = '{16'h0000, 4'd0, 4'd1, 1'b0, 4'd5, 16'h0000};
        tbl[6]  = '{16'h0000, 4'd0, 4'd1, 1'b0, 4'd5, 16'h0000};
        tbl[7]  = '{16'h0080, 4'd0, 4'd7, 1'b0, 4'd5, 16'h0000};
        tbl[8]  = '{16'h0080, 4'd0, 4'd7, 1'b0, 4'd5, 16'h0000};
        tbl[9]  = '{16'h0080, 4'd0, 4'd7, 1'b0, 4'd5, 16'h0000};
        tbl[10] = '{16'h0080, 4'd0, 4'd7, 1'b0, 4'd5, 16'h0000};
        tbl[11] = '{16'h0000, 4'd0, 4'd1, 1'b0, 4'd5, 16'h0000};
        tbl[12] = '{16'h0000, 4'd0, 4'd1, 1'b0, 4'd5, 16'h0000};
        tbl[13] = '{16'h0014, 4'd0, 4'd1, 1'b0, 4'd5, 16'h0000};
        tbl[14] = '{16'h0014, 4'd0, 4'd1, 1'b0, 4'd5, 16'h0000};
        tbl[15] = '{16'h0000, 4'd0, 4'd1, 1'b0, 4'd5, 16'h0014};
        tbl[16] = '{16'h0000, 4'd0, 4'd1, 1'b1, 4'd2, 16'h0010};
        tbl[17] = '{16'h0000, 4'd0, 4'd1, 1'b0, 4'd2, 16'h0010};
        tbl[18] = '{16'h0000, 4'd0, 4'd1, 1'b0, 4'd2, 16'h0010};
        tbl[19] = '{16'h0000, 4'd0, 4'd1, 1'b1, 4'd4, 16'h0000};
        tbl[20] = '{16'h0000, 4'd0, 4'd1, 1'b0, 4'd4, 16'h0000};

        for (int r = 0; r < 21; r++) begin
            btn = tbl[r].btn; fl1 = tbl[r].fl1; fl2 = tbl[r].fl2;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec[%0d] valid", r), 32'(req_valid), 32'(tbl[r].vld));
            chk($sformatf("vec[%0d] new", r), 32'(req_new), 32'(tbl[r].nw));
            chk($sformatf("vec[%0d] pending", r), 32'(pending), 32'(tbl[r].pend));
        end

        // Seed rr_ptr to 10 by emitting floor 9, then raise 3, 9, 12 together
        tick(4);
        m = emq.size();
        btn = 16'h0200; tick(2); btn = '0; tick(8);
        chk("rr seed count", 32'(emq.size() - m), 1);
        if (emq.size() > m) chk("rr seed floor", 32'(emq[m].f), 9);

        m = emq.size(); pc = cyc;
        btn = 16'h1208; tick(3); btn = '0; tick(14);
        exp_f = '{12, 3, 9};
        chk("rr burst count", 32'(emq.size() - m), 3);
        for (int i = 0; i < 3; i++) begin
            if (m + i < emq.size()) begin
                chk($sformatf("rr burst[%0d] floor", i), 32'(emq[m+i].f), 32'(exp_f[i]));
                chk($sformatf("rr burst[%0d] cycle", i), 32'(emq[m+i].t), 32'(pc + 4 + 3 * i));
            end
        end
        chk("rr burst pending", 32'(pending), 0);

        // Floor 4 pended, then lift 1 arrives before it can be emitted
        m = emq.size();
        btn = 16'h0010; tick(3);
        chk("lift clear pended", 32'(pending), 32'h0010);
        fl1 = 4'd4; tick(1);
        chk("lift clear pending", 32'(pending), 0);
        chk("lift clear valid", 32'(req_valid), 0);
        btn = '0; tick(1); fl1 = 4'd0; tick(6);
        chk("lift clear no emit", 32'(emq.size() - m), 0);

        // Floor 1 emits first; floor 2 re-pressed in the cycle it is emitted
        fl1 = 4'd14; fl2 = 4'd15;
        m = emq.size();
        btn = 16'h0002; tick(1); btn = '0; tick(1);
        btn = 16'h0004; tick(1); btn = '0; tick(1);
        btn = 16'h0004; tick(10); btn = '0; tick(8);
        chk("repress count", 32'(emq.size() - m), 2);
        n2 = 0;
        for (int i = m; i < emq.size(); i++) if (emq[i].f == 4'd2) n2++;
        chk("repress floor2 once", 32'(n2), 1);
        if (emq.size() >= m + 2) begin
            chk("repress first floor", 32'(emq[m].f), 1);
            chk("repress spacing", 32'(emq[m+1].t - emq[m].t), 3);
        end
        chk("repress pending", 32'(pending), 0);

        // Reset in the middle of a burst, with buttons held through release
        fl1 = 4'd0; fl2 = 4'd1;
        btn = 16'h1248; tick(4);
        chk("pre-reset valid", 32'(req_valid), 1);
        chk("pre-reset new", 32'(req_new), 3);
        chk("pre-reset pending", 32'(pending), 32'h1240);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset valid", 32'(req_valid), 0);
        chk("async reset new", 32'(req_new), 0);
        chk("async reset pending", 32'(pending), 0);
        tick(2);
        rst_n = 1'b1;
        m = emq.size();
        tick(12);
        chk("held through reset emits", 32'(emq.size() - m), 0);
        chk("held through reset pending", 32'(pending), 0);
        btn = '0; tick(3);
        m = emq.size(); pc = cyc;
        btn = 16'h0040; tick(2); btn = '0; tick(6);
        chk("re-press count", 32'(emq.size() - m), 1);
        if (emq.size() > m) begin
            chk("re-press floor", 32'(emq[m].f), 6);
            chk("re-press cycle", 32'(emq[m].t), 32'(pc + 4));
        end
`else
        // Debounced build: 3 high samples are ignored, 4 produce one call
        fl1 = 4'd14; fl2 = 4'd15;
        m = emq.size();
        btn = 16'h0002; tick(3); btn = '0; tick(10);
        chk("deb short count", 32'(emq.size() - m), 0);
        chk("deb short pending", 32'(pending), 0);
        m = emq.size(); pc = cyc;
        btn = 16'h0002; tick(4); btn = '0; tick(10);
        chk("deb press count", 32'(emq.size() - m), 1);
        if (emq.size() > m) begin
            chk("deb press floor", 32'(emq[m].f), 1);
            chk("deb press cycle", 32'(emq[m].t), 32'(pc + 1 + DEB + 2));
        end
        m = emq.size();
        btn = 16'h0002; tick(12); btn = '0; tick(8);
        chk("deb long hold count", 32'(emq.size() - m), 1);
        chk("deb long hold pending", 32'(pending), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
